// File: rtl/seq_pkg.sv
// ============================================================================
// seq_pkg: state encodings and default word width for the serializer/detector.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } st_e;

endpackage

`default_nettype wire

// File: rtl/bit_serializer_if.sv
// ============================================================================
// bit_serializer_if: parallel-word handshake in, serial stream out.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bit_serializer_if
  import seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, ser_out, ser_valid, word_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, ser_out, ser_valid, word_done, busy
  );
endinterface

`default_nettype wire

// File: rtl/hold_buf.sv
// ============================================================================
// hold_buf: one-entry word buffer; accepts when empty, empties on load strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hold_buf
  import seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] din_i,
  input  wire logic             din_valid_i,
  input  wire logic             load_i,
  output logic      [WIDTH-1:0] hbuf_o,
  output logic                  hvalid_o,
  output logic                  din_ready_o
);
  logic [WIDTH-1:0] hbuf_q, hbuf_d;
  logic             hvalid_q, hvalid_d;

  assign din_ready_o = rst && !hvalid_q;
  assign hbuf_o      = hbuf_q;
  assign hvalid_o    = hvalid_q;

  // Accept needs an empty buffer and load needs a full one, so they never coincide.
  always_comb begin
    hbuf_d   = hbuf_q;
    hvalid_d = hvalid_q;
    if (load_i) begin
      hvalid_d = 1'b0;
    end
    if (din_valid_i && din_ready_o) begin
      hbuf_d   = din_i;
      hvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hbuf_q   <= '0;
      hvalid_q <= 1'b0;
    end else begin
      hbuf_q   <= hbuf_d;
      hvalid_q <= hvalid_d;
    end
  end
endmodule

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
// bit_serializer: parallel words in, gap-free one-bit-per-clock stream out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int MSB_FIRST = 1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  bit_serializer_if.slave bus
);
  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

  st_e              st_q, st_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hbuf;
  logic             hvalid;
  logic             din_ready;
  logic             head_bit;
  logic             last_bit;
  logic             load;

  hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
    .clk         (clk),
    .rst         (rst),
    .din_i       (bus.din),
    .din_valid_i (bus.din_valid),
    .load_i      (load),
    .hbuf_o      (hbuf),
    .hvalid_o    (hvalid),
    .din_ready_o (din_ready)
  );

  assign last_bit = (st_q == ST_SHIFT) && (cnt_q == c_last);
  // A buffered word loads on the edge retiring the last bit, giving zero gap.
  assign load     = hvalid && ((st_q == ST_IDLE) || last_bit);

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign head_bit = sreg_q[WIDTH-1];
    end else begin : g_lsb_first
      assign head_bit = sreg_q[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    if (load) begin
      st_d = ST_SHIFT;
    end else if (last_bit) begin
      st_d = ST_IDLE;
    end
  end

  always_comb begin
    bus.ser_out   = (st_q == ST_SHIFT) ? head_bit : IDLE_BIT;
    bus.ser_valid = (st_q == ST_SHIFT);
    bus.word_done = last_bit;
    bus.busy      = (st_q == ST_SHIFT) || hvalid;
    bus.din_ready = din_ready;
  end

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load) begin
      sreg_d = hbuf;
      cnt_d  = '0;
    end else if ((st_q == ST_SHIFT) && (cnt_q != c_last)) begin
      cnt_d  = cnt_q + 1'b1;
      sreg_d = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// ============================================================================
// tb_bit_serializer: directed checks on an 8-bit MSB-first and a 4-bit LSB-first serializer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bit_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) ifa ();
  bit_serializer_if #(.WIDTH(4)) ifb ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  bit_serializer #(.WIDTH(4), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_stream(input string tag, input int n, input logic [7:0] w0,
                            input logic [7:0] w1, input logic [7:0] w2,
                            input logic [23:0] exp);
    int          acc = 0;
    int          nb = 0;
    bit          started = 0;
    bit          gap = 0;
    logic        take;
    logic [23:0] s = '0;
    for (int c = 0; c < 80 && nb < n * 8; c++) begin
      ifa.din_valid = (acc < n);
      ifa.din       = (acc == 0) ? w0 : (acc == 1) ? w1 : w2;
      take          = ifa.din_valid && ifa.din_ready;
      tick();
      if (take) begin
        acc++;
        chk($sformatf("%s_ready_low_after_accept%0d", tag, acc), 32'(ifa.din_ready), 32'd0);
      end
      if (ifa.ser_valid) begin
        s = {s[22:0], ifa.ser_out};
        nb++;
        started = 1;
      end else if (started) begin
        gap = 1;
      end
    end
    ifa.din_valid = 1'b0;
    chk({tag, "_words_accepted"}, 32'(acc), 32'(n));
    chk({tag, "_bit_count"}, 32'(nb), 32'(n * 8));
    chk({tag, "_gap"}, 32'(gap), 32'd0);
    chk({tag, "_stream"}, 32'(s), 32'(exp));
    tick();
    chk({tag, "_valid_after"}, 32'(ifa.ser_valid), 32'd0);
    chk({tag, "_busy_after"}, 32'(ifa.busy), 32'd0);
  endtask

  initial begin
    logic [7:0] pat8;
    logic [3:0] pat4;
    int         vcount;

    ifa.din = '0;
    ifa.din_valid = 1'b0;
    ifb.din = '0;
    ifb.din_valid = 1'b0;

    // Reset held for three edges
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_ser_out", 32'(ifa.ser_out), 32'd0);
    chk("rst_ser_valid", 32'(ifa.ser_valid), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_din_ready", 32'(ifa.din_ready), 32'd0);
    chk("rst_b_din_ready", 32'(ifb.din_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_din_ready", 32'(ifa.din_ready), 32'd1);
    chk("rel_b_din_ready", 32'(ifb.din_ready), 32'd1);
    tick();
    chk("rel_word_done", 32'(ifa.word_done), 32'd0);

    // Single word 8'hB0, MSB first
    ifa.din = 8'hB0;
    ifa.din_valid = 1'b1;
    tick();
    ifa.din_valid = 1'b0;
    ifa.din = 8'h00;
    chk("single_latency_valid", 32'(ifa.ser_valid), 32'd0);
    chk("single_buffered_busy", 32'(ifa.busy), 32'd1);
    chk("single_buffered_ready", 32'(ifa.din_ready), 32'd0);
    pat8 = 8'b1011_0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("single_bit%0d", i), 32'(ifa.ser_out), 32'(pat8[7-i]));
      chk($sformatf("single_valid%0d", i), 32'(ifa.ser_valid), 32'd1);
      chk($sformatf("single_done%0d", i), 32'(ifa.word_done), 32'(i == 7));
    end
    tick();
    chk("single_idle_out", 32'(ifa.ser_out), 32'd0);
    chk("single_idle_valid", 32'(ifa.ser_valid), 32'd0);
    chk("single_idle_busy", 32'(ifa.busy), 32'd0);

    // Back-to-back and backpressure
    run_stream("b2b", 2, 8'hA5, 8'h3C, 8'h00, 24'h00A53C);
    run_stream("bp", 3, 8'h81, 8'h5A, 8'hC3, 24'h815AC3);

    // Reset mid-word with a buffered word
    ifa.din = 8'hFF;
    ifa.din_valid = 1'b1;
    tick();
    ifa.din = 8'h0F;
    tick();
    chk("midrst_ready_refill", 32'(ifa.din_ready), 32'd1);
    tick();
    ifa.din_valid = 1'b0;
    chk("midrst_buffered_ready", 32'(ifa.din_ready), 32'd0);
    tick();
    chk("midrst_bit3_out", 32'(ifa.ser_out), 32'd1);
    chk("midrst_busy_before", 32'(ifa.busy), 32'd1);
    rst = 1'b0;
    tick();
    chk("midrst_valid", 32'(ifa.ser_valid), 32'd0);
    chk("midrst_out", 32'(ifa.ser_out), 32'd0);
    chk("midrst_busy", 32'(ifa.busy), 32'd0);
    chk("midrst_done", 32'(ifa.word_done), 32'd0);
    rst = 1'b1;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ifa.ser_valid) vcount++;
    end
    chk("midrst_no_residue", 32'(vcount), 32'd0);
    chk("midrst_ready_after", 32'(ifa.din_ready), 32'd1);

    // LSB-first, WIDTH=4
    pat4 = 4'b0011;
    ifb.din = pat4;
    ifb.din_valid = 1'b1;
    tick();
    ifb.din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("lsb_bit%0d", i), 32'(ifb.ser_out), 32'(pat4[i]));
      chk($sformatf("lsb_done%0d", i), 32'(ifb.word_done), 32'(i == 3));
    end
    tick();
    chk("lsb_idle_valid", 32'(ifb.ser_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
